// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the hazard control unit and its forwarding sub-module.
// Optional statistics counters are controlled by HAZARD_STATS_EN (see hazard_control_unit).
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hzd_state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-stage register addresses and controls seen by the hazard unit, plus its outputs.
interface hazard_control_unit_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addressRsId;
    logic [ADDR_W-1:0] addressRtId;
    logic              usesRtId;
    logic              branchId;
    logic [ADDR_W-1:0] addressRsEx;
    logic [ADDR_W-1:0] addressRtEx;
    logic              regWriteEx;
    logic              memReadEx;
    logic [ADDR_W-1:0] regWriteRegisterEx;
    logic              regWriteMemInput;
    logic              memReadMemInput;
    logic [ADDR_W-1:0] regWriteRegisterMemInput;
    logic              regWriteWbInput;
    logic [ADDR_W-1:0] regWriteAddressWbInput;
    logic              hazard;
    logic              redirectEnableId;
    logic [1:0]        forwardingMux0Ex;
    logic [1:0]        forwardingMux1Ex;

    modport master (
        output addressRsId, addressRtId, usesRtId, branchId,
        output addressRsEx, addressRtEx, regWriteEx, memReadEx, regWriteRegisterEx,
        output regWriteMemInput, memReadMemInput, regWriteRegisterMemInput,
        output regWriteWbInput, regWriteAddressWbInput,
        input  hazard, redirectEnableId, forwardingMux0Ex, forwardingMux1Ex
    );

    modport slave (
        input  addressRsId, addressRtId, usesRtId, branchId,
        input  addressRsEx, addressRtEx, regWriteEx, memReadEx, regWriteRegisterEx,
        input  regWriteMemInput, memReadMemInput, regWriteRegisterMemInput,
        input  regWriteWbInput, regWriteAddressWbInput,
        output hazard, redirectEnableId, forwardingMux0Ex, forwardingMux1Ex
    );

endinterface

// File: rtl/hazard_control_unit_forwarding.sv
// Combinational EX-stage forwarding select generation for both ALU operands.
module forwarding_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_ex,
    input  logic [ADDR_W-1:0] rt_ex,
    input  logic              mem_we,
    input  logic              mem_rd,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_dst,
    output fwd_sel_t          sel_a,
    output fwd_sel_t          sel_b
);

    // A load in MEM has no ALU result worth forwarding; its consumer waits for WB.
    function automatic fwd_sel_t pick(
        input logic [ADDR_W-1:0] src,
        input logic              m_we,
        input logic              m_rd,
        input logic [ADDR_W-1:0] m_dst,
        input logic              w_we,
        input logic [ADDR_W-1:0] w_dst
    );
        if (m_we && !m_rd && m_dst != ADDR_W'(ZERO_REG) && m_dst == src)
            return FWD_MEM;
        if (w_we && w_dst != ADDR_W'(ZERO_REG) && w_dst == src)
            return FWD_WB;
        return FWD_REG;
    endfunction

    always_comb begin
        sel_a = pick(rs_ex, mem_we, mem_rd, mem_dst, wb_we, wb_dst);
        sel_b = pick(rt_ex, mem_we, mem_rd, mem_dst, wb_we, wb_dst);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use / branch-in-ID stall sequencing and EX forwarding selects.
// Define HAZARD_STATS_EN to add stallCycles and loadUseEvents counter outputs.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave hcu
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stallCycles,
    output logic [31:0]          loadUseEvents
`endif
);

    localparam logic BRANCH_EN = (BRANCH_IN_ID != 0);

    hzd_state_t state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;

    logic       load_use;
    logic       br_ex;
    logic       br_mem;
    logic [1:0] need;
    logic       hazard_raw;
    logic       hazard_int;
    fwd_sel_t   sel_a, sel_b;

    forwarding_unit #(
        .ADDR_W (ADDR_W)
    ) u_fwd (
        .rs_ex   (hcu.addressRsEx),
        .rt_ex   (hcu.addressRtEx),
        .mem_we  (hcu.regWriteMemInput),
        .mem_rd  (hcu.memReadMemInput),
        .mem_dst (hcu.regWriteRegisterMemInput),
        .wb_we   (hcu.regWriteWbInput),
        .wb_dst  (hcu.regWriteAddressWbInput),
        .sel_a   (sel_a),
        .sel_b   (sel_b)
    );

    // Dependency checks against the instruction in ID; WB producers are covered by write-first RF.
    always_comb begin
        load_use = hcu.memReadEx
                && hcu.regWriteRegisterEx != ADDR_W'(ZERO_REG)
                && (hcu.regWriteRegisterEx == hcu.addressRsId
                    || (hcu.usesRtId && hcu.regWriteRegisterEx == hcu.addressRtId));
        br_ex    = BRANCH_EN && hcu.branchId && hcu.regWriteEx
                && hcu.regWriteRegisterEx != ADDR_W'(ZERO_REG)
                && (hcu.regWriteRegisterEx == hcu.addressRsId
                    || hcu.regWriteRegisterEx == hcu.addressRtId);
        br_mem   = BRANCH_EN && hcu.branchId && hcu.regWriteMemInput
                && hcu.regWriteRegisterMemInput != ADDR_W'(ZERO_REG)
                && (hcu.regWriteRegisterMemInput == hcu.addressRsId
                    || hcu.regWriteRegisterMemInput == hcu.addressRtId);
        need     = max_need(max_need(load_use ? 2'd1 : 2'd0, br_ex ? 2'd2 : 2'd0),
                            br_mem ? 2'd1 : 2'd0);
    end

    // A 1-cycle stall resolves itself by re-evaluation; only 2-cycle stalls enter STALL.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        hazard_raw  = 1'b0;
        case (state_q)
            RUN: begin
                hazard_raw = (need != 2'd0);
                if (need == 2'd2) begin
                    state_d     = STALL;
                    stall_cnt_d = 2'd1;
                end
            end
            STALL: begin
                hazard_raw = 1'b1;
                if (stall_cnt_q != 2'd0)
                    stall_cnt_d = stall_cnt_q - 2'd1;
                if (stall_cnt_q <= 2'd1)
                    state_d = RUN;
            end
            default: begin
                state_d     = RUN;
                stall_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        hazard_int           = !reset && hazard_raw;
        hcu.hazard           = hazard_int;
        hcu.redirectEnableId = !hazard_int;
        hcu.forwardingMux0Ex = reset ? FWD_REG : sel_a;
        hcu.forwardingMux1Ex = reset ? FWD_REG : sel_b;
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] load_use_events_q, load_use_events_d;

    always_comb begin
        stall_cycles_d    = stall_cycles_q + (hazard_int ? 32'd1 : 32'd0);
        load_use_events_d = load_use_events_q
                          + ((state_q == RUN && load_use) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            load_use_events_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            load_use_events_q <= load_use_events_d;
        end
    end

    assign stallCycles   = stall_cycles_q;
    assign loadUseEvents = load_use_events_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit: forwarding selects, stall lengths and reset.
module tb_hazard_control_unit;

    logic clk;
    logic reset;
    int   vectors;
    int   errs;

    hazard_control_unit_if #(.ADDR_W(5)) hif ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stallCycles;
    logic [31:0] loadUseEvents;
`endif

    hazard_control_unit #(
        .ADDR_W       (5),
        .BRANCH_IN_ID (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hcu   (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stallCycles   (stallCycles),
        .loadUseEvents (loadUseEvents)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.addressRsId              = '0;
        hif.addressRtId              = '0;
        hif.usesRtId                 = 1'b0;
        hif.branchId                 = 1'b0;
        hif.addressRsEx              = '0;
        hif.addressRtEx              = '0;
        hif.regWriteEx               = 1'b0;
        hif.memReadEx                = 1'b0;
        hif.regWriteRegisterEx       = '0;
        hif.regWriteMemInput         = 1'b0;
        hif.memReadMemInput          = 1'b0;
        hif.regWriteRegisterMemInput = '0;
        hif.regWriteWbInput          = 1'b0;
        hif.regWriteAddressWbInput   = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled mid low phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        reset   = 1'b1;
        clear_inputs();
        // Reset with a live load-use dependency and a MEM forward on the inputs.
        hif.memReadEx                = 1'b1;
        hif.regWriteEx               = 1'b1;
        hif.regWriteRegisterEx       = 5'd3;
        hif.addressRsId              = 5'd3;
        hif.regWriteMemInput         = 1'b1;
        hif.regWriteRegisterMemInput = 5'd4;
        hif.addressRsEx              = 5'd4;
        tick();
        tick();
        chk("rst_hazard", {31'd0, hif.hazard}, 32'd0);
        chk("rst_redirect", {31'd0, hif.redirectEnableId}, 32'd1);
        chk("rst_fwd0", {30'd0, hif.forwardingMux0Ex}, 32'd0);
        chk("rst_fwd1", {30'd0, hif.forwardingMux1Ex}, 32'd0);
`ifdef HAZARD_STATS_EN
        chk("rst_stalls", stallCycles, 32'd0);
        chk("rst_luevents", loadUseEvents, 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("post_rst_hazard", {31'd0, hif.hazard}, 32'd1);
        chk("post_rst_fwd0", {30'd0, hif.forwardingMux0Ex}, 32'd2);

        // MEM beats WB on the same register; a load in MEM falls back to WB.
        clear_inputs();
        hif.regWriteMemInput         = 1'b1;
        hif.regWriteRegisterMemInput = 5'd8;
        hif.regWriteWbInput          = 1'b1;
        hif.regWriteAddressWbInput   = 5'd8;
        hif.addressRsEx              = 5'd8;
        #1;
        chk("fwd_mem_prio", {30'd0, hif.forwardingMux0Ex}, 32'd2);
        chk("fwd_mem_rt_none", {30'd0, hif.forwardingMux1Ex}, 32'd0);
        hif.memReadMemInput = 1'b1;
        #1;
        chk("fwd_load_in_mem", {30'd0, hif.forwardingMux0Ex}, 32'd1);
        hif.memReadMemInput          = 1'b0;
        hif.regWriteRegisterMemInput = 5'd0;
        hif.regWriteAddressWbInput   = 5'd0;
        hif.addressRsEx              = 5'd0;
        #1;
        chk("fwd_reg0", {30'd0, hif.forwardingMux0Ex}, 32'd0);

        // WB forward on rt only.
        clear_inputs();
        hif.regWriteWbInput        = 1'b1;
        hif.regWriteAddressWbInput = 5'd9;
        hif.addressRtEx            = 5'd9;
        hif.addressRsEx            = 5'd7;
        #1;
        chk("fwd_wb_rt", {30'd0, hif.forwardingMux1Ex}, 32'd1);
        chk("fwd_wb_rs", {30'd0, hif.forwardingMux0Ex}, 32'd0);
        tick();

        // Load-use on rt ignored when rt is not read.
        clear_inputs();
        hif.memReadEx          = 1'b1;
        hif.regWriteEx         = 1'b1;
        hif.regWriteRegisterEx = 5'd10;
        hif.addressRtId        = 5'd10;
        #1;
        chk("lu_no_rt", {31'd0, hif.hazard}, 32'd0);
        hif.usesRtId = 1'b1;
        #1;
        chk("lu_hazard", {31'd0, hif.hazard}, 32'd1);
        chk("lu_redirect", {31'd0, hif.redirectEnableId}, 32'd0);
        tick();
        clear_inputs();
        hif.addressRtId              = 5'd10;
        hif.usesRtId                 = 1'b1;
        hif.regWriteMemInput         = 1'b1;
        hif.memReadMemInput          = 1'b1;
        hif.regWriteRegisterMemInput = 5'd10;
        #1;
        chk("lu_released", {31'd0, hif.hazard}, 32'd0);
        tick();
        clear_inputs();
        hif.addressRtEx            = 5'd10;
        hif.regWriteWbInput        = 1'b1;
        hif.regWriteAddressWbInput = 5'd10;
        #1;
        chk("lu_fwd_wb", {30'd0, hif.forwardingMux1Ex}, 32'd1);
        tick();

        // Branch depending on an ALU op in EX: two stall cycles.
        clear_inputs();
        hif.branchId           = 1'b1;
        hif.addressRsId        = 5'd11;
        hif.regWriteEx         = 1'b1;
        hif.regWriteRegisterEx = 5'd11;
        #1;
        chk("brex_c0_hazard", {31'd0, hif.hazard}, 32'd1);
        chk("brex_c0_redirect", {31'd0, hif.redirectEnableId}, 32'd0);
        tick();
        hif.regWriteEx               = 1'b0;
        hif.regWriteRegisterEx       = 5'd0;
        hif.regWriteMemInput         = 1'b1;
        hif.regWriteRegisterMemInput = 5'd11;
        #1;
        chk("brex_c1_hazard", {31'd0, hif.hazard}, 32'd1);
        chk("brex_c1_redirect", {31'd0, hif.redirectEnableId}, 32'd0);
        tick();
        hif.regWriteMemInput         = 1'b0;
        hif.regWriteRegisterMemInput = 5'd0;
        hif.regWriteWbInput          = 1'b1;
        hif.regWriteAddressWbInput   = 5'd11;
        #1;
        chk("brex_c2_hazard", {31'd0, hif.hazard}, 32'd0);
        chk("brex_c2_redirect", {31'd0, hif.redirectEnableId}, 32'd1);
        tick();

        // Branch depending on a MEM producer alone: one stall cycle.
        clear_inputs();
        hif.branchId                 = 1'b1;
        hif.addressRtId              = 5'd14;
        hif.regWriteMemInput         = 1'b1;
        hif.regWriteRegisterMemInput = 5'd14;
        #1;
        chk("brmem_c0_hazard", {31'd0, hif.hazard}, 32'd1);
        tick();
        hif.regWriteMemInput         = 1'b0;
        hif.regWriteRegisterMemInput = 5'd0;
        hif.regWriteWbInput          = 1'b1;
        hif.regWriteAddressWbInput   = 5'd14;
        #1;
        chk("brmem_c1_hazard", {31'd0, hif.hazard}, 32'd0);
        tick();

        // Reset while in STALL suppresses hazard and returns to RUN.
        clear_inputs();
        hif.branchId           = 1'b1;
        hif.addressRsId        = 5'd5;
        hif.regWriteEx         = 1'b1;
        hif.regWriteRegisterEx = 5'd5;
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("rst_in_stall_hazard", {31'd0, hif.hazard}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_in_stall_run", {31'd0, hif.hazard}, 32'd0);
`ifdef HAZARD_STATS_EN
        chk("rst_in_stall_cnt", stallCycles, 32'd0);
`endif

        // Branch after load with load-use and branch-MEM both active: 2 stalls, not 3.
        hif.branchId                 = 1'b1;
        hif.addressRsId              = 5'd12;
        hif.addressRtId              = 5'd13;
        hif.usesRtId                 = 1'b1;
        hif.memReadEx                = 1'b1;
        hif.regWriteEx               = 1'b1;
        hif.regWriteRegisterEx       = 5'd12;
        hif.regWriteMemInput         = 1'b1;
        hif.regWriteRegisterMemInput = 5'd13;
        #1;
        chk("brld_c0_hazard", {31'd0, hif.hazard}, 32'd1);
        tick();
        hif.memReadEx                = 1'b0;
        hif.regWriteEx               = 1'b0;
        hif.regWriteRegisterEx       = 5'd0;
        hif.memReadMemInput          = 1'b1;
        hif.regWriteRegisterMemInput = 5'd12;
        hif.regWriteWbInput          = 1'b1;
        hif.regWriteAddressWbInput   = 5'd13;
        #1;
        chk("brld_c1_hazard", {31'd0, hif.hazard}, 32'd1);
        tick();
        hif.regWriteMemInput         = 1'b0;
        hif.memReadMemInput          = 1'b0;
        hif.regWriteRegisterMemInput = 5'd0;
        hif.regWriteAddressWbInput   = 5'd12;
        #1;
        chk("brld_c2_hazard", {31'd0, hif.hazard}, 32'd0);
        chk("brld_c2_redirect", {31'd0, hif.redirectEnableId}, 32'd1);
        tick();
`ifdef HAZARD_STATS_EN
        chk("stats_stalls", stallCycles, 32'd2);
        chk("stats_luevents", loadUseEvents, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
